// File: rtl/int_ctrl.sv
// int_ctrl -- interrupt controller for the RAT MCU.
//
// Latches rising edges on up to eight peripheral interrupt lines as pending
// bits. It gates them with a software mask and raises one registered request
// (INT_R) to the control unit. INT_R stays high until the control unit
// acknowledges. The controller then records the source in service and waits
// for a software EOI write before it raises the next request.
//
// Ports:
//   CLK       in   system clock, rising-edge
//   RESET     in   synchronous active-high reset
//   IRQ_IN    in   [N_SRC] interrupt lines (synchronous, rising-edge sensitive)
//   PORT_ID   in   [8] I/O port address
//   OUT_PORT  in   [8] I/O write data
//   IO_STRB   in   one-cycle I/O write strobe
//   INT_ACK   in   one-cycle acknowledge from the control unit
//   INT_R     out  registered interrupt request
//   RD_DATA   out  [8] combinational read data for PORT_ID (0 if unmapped)
//   RD_HIT    out  high when PORT_ID addresses one of this block's ports
module int_ctrl #(
    parameter int          N_SRC     = 8,
    parameter logic [7:0]  MASK_PORT = 8'h20,
    parameter logic [7:0]  PEND_PORT = 8'h21,
    parameter logic [7:0]  EOI_PORT  = 8'h22
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N_SRC-1:0] IRQ_IN,
    input  logic [7:0]       PORT_ID,
    input  logic [7:0]       OUT_PORT,
    input  logic             IO_STRB,
    input  logic             INT_ACK,
    output logic             INT_R,
    output logic [7:0]       RD_DATA,
    output logic             RD_HIT
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t           state_q, state_d;
    logic [N_SRC-1:0] irq_prev_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [2:0]       cur_id_q, cur_id_d;
    logic             int_r_q, int_r_d;

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] active;
    logic [N_SRC-1:0] sel_oh;
    logic [N_SRC-1:0] clr;
    logic [2:0]       sel;
    logic             mask_wr;
    logic             eoi_wr;
    logic             ack_take;

    assign rise    = IRQ_IN & ~irq_prev_q;
    assign active  = pending_q & mask_q;
    assign mask_wr = IO_STRB && (PORT_ID == MASK_PORT);
    assign eoi_wr  = IO_STRB && (PORT_ID == EOI_PORT);
    // An acknowledge counts only while a request is actually outstanding.
    assign ack_take = (state_q == REQ) && INT_ACK;

    // Priority pick: scanning from the top down leaves the lowest set index.
    always_comb begin
        sel    = 3'd0;
        sel_oh = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                sel       = 3'(i);
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
            end
        end
    end

    // New edges win over a clear of the same bit in the same cycle, so an
    // edge that coincides with EOI or ACK is never lost.
    always_comb begin
        clr = '0;
        if (eoi_wr) begin
            clr = clr | OUT_PORT[N_SRC-1:0];
        end
        if (ack_take) begin
            clr = clr | sel_oh;
        end
        pending_d = (pending_q & ~clr) | rise;
        mask_d    = mask_wr ? OUT_PORT[N_SRC-1:0] : mask_q;
    end

    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        case (state_q)
            IDLE: begin
                if (|active) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (INT_ACK) begin
                    state_d  = SERVICE;
                    cur_id_d = sel;
                end else if (active == '0) begin
                    // Source masked or cleared before the ACK: withdraw.
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (eoi_wr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        int_r_d = (state_d == REQ);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            irq_prev_q <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            cur_id_q   <= 3'd0;
            int_r_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            irq_prev_q <= IRQ_IN;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            cur_id_q   <= cur_id_d;
            int_r_q    <= int_r_d;
        end
    end

    assign INT_R = int_r_q;

    always_comb begin
        RD_DATA = 8'h00;
        RD_HIT  = 1'b0;
        if (PORT_ID == MASK_PORT) begin
            RD_DATA[N_SRC-1:0] = mask_q;
            RD_HIT             = 1'b1;
        end else if (PORT_ID == PEND_PORT) begin
            RD_DATA[N_SRC-1:0] = pending_q;
            RD_HIT             = 1'b1;
        end else if (PORT_ID == EOI_PORT) begin
            RD_DATA = {4'b0000, (state_q == SERVICE), cur_id_q};
            RD_HIT  = 1'b1;
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed testbench for int_ctrl: one task per scenario, called in sequence.
module tb_int_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] IRQ_IN;
    logic [7:0] PORT_ID;
    logic [7:0] OUT_PORT;
    logic       IO_STRB;
    logic       INT_ACK;
    logic       INT_R;
    logic [7:0] RD_DATA;
    logic       RD_HIT;

    int n_checks = 0;
    int n_fail   = 0;

    int_ctrl #(.N_SRC(8)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .IRQ_IN  (IRQ_IN),
        .PORT_ID (PORT_ID),
        .OUT_PORT(OUT_PORT),
        .IO_STRB (IO_STRB),
        .INT_ACK (INT_ACK),
        .INT_R   (INT_R),
        .RD_DATA (RD_DATA),
        .RD_HIT  (RD_HIT)
    );

    always #5 CLK = ~CLK;

    // Advance past one rising edge; inputs change and outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [7:0] port, input logic [7:0] data);
        PORT_ID  = port;
        OUT_PORT = data;
        IO_STRB  = 1'b1;
        tick();
        IO_STRB  = 1'b0;
        OUT_PORT = 8'h00;
    endtask

    task automatic rd(input logic [7:0] port);
        PORT_ID = port;
        #1;
    endtask

    task automatic ack();
        INT_ACK = 1'b1;
        tick();
        INT_ACK = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; IRQ_IN = 8'h00; PORT_ID = 8'h00; OUT_PORT = 8'h00;
        IO_STRB = 1'b0; INT_ACK = 1'b0;
        tick(); tick();
        RESET = 1'b0;
        n_checks++;
        if (INT_R !== 1'b0) begin n_fail++; $display("FAIL reset_intr: INT_R=%b expected 0", INT_R); end
        rd(8'h21);
        n_checks++;
        if (RD_DATA !== 8'h00 || RD_HIT !== 1'b1) begin n_fail++; $display("FAIL reset_pend: RD_DATA=%h RD_HIT=%b expected 00/1", RD_DATA, RD_HIT); end
        rd(8'h30);
        n_checks++;
        if (RD_DATA !== 8'h00 || RD_HIT !== 1'b0) begin n_fail++; $display("FAIL unmapped_rd: RD_DATA=%h RD_HIT=%b expected 00/0", RD_DATA, RD_HIT); end
        wr(8'h20, 8'hFF);
        rd(8'h20);
        n_checks++;
        if (RD_DATA !== 8'hFF || RD_HIT !== 1'b1 || INT_R !== 1'b0) begin n_fail++; $display("FAIL mask_rdback: RD_DATA=%h RD_HIT=%b INT_R=%b expected FF/1/0", RD_DATA, RD_HIT, INT_R); end
    endtask

    task automatic test_single();
        IRQ_IN = 8'h08;
        tick();                 // edge k: rise sampled, pending set
        IRQ_IN = 8'h00;
        n_checks++;
        if (INT_R !== 1'b0) begin n_fail++; $display("FAIL single_lat1: INT_R=%b expected 0", INT_R); end
        tick();                 // edge k+1: request raised
        n_checks++;
        if (INT_R !== 1'b1) begin n_fail++; $display("FAIL single_lat2: INT_R=%b expected 1", INT_R); end
        ack();
        n_checks++;
        if (INT_R !== 1'b0) begin n_fail++; $display("FAIL single_ackdrop: INT_R=%b expected 0", INT_R); end
        rd(8'h22);
        n_checks++;
        if (RD_DATA !== 8'h0B) begin n_fail++; $display("FAIL single_insvc: RD_DATA=%h expected 0B", RD_DATA); end
        rd(8'h21);
        n_checks++;
        if (RD_DATA !== 8'h00) begin n_fail++; $display("FAIL single_pend: RD_DATA=%h expected 00", RD_DATA); end
        wr(8'h22, 8'h00);
        tick();
        rd(8'h22);
        n_checks++;
        if (INT_R !== 1'b0 || RD_DATA[3] !== 1'b0) begin n_fail++; $display("FAIL single_eoi: INT_R=%b insvc=%b expected 0/0", INT_R, RD_DATA[3]); end
    endtask

    task automatic test_priority();
        IRQ_IN = 8'h24;
        tick();
        IRQ_IN = 8'h00;
        tick();
        n_checks++;
        if (INT_R !== 1'b1) begin n_fail++; $display("FAIL prio_req: INT_R=%b expected 1", INT_R); end
        ack();
        rd(8'h22);
        n_checks++;
        if (RD_DATA !== 8'h0A) begin n_fail++; $display("FAIL prio_first: RD_DATA=%h expected 0A", RD_DATA); end
        rd(8'h21);
        n_checks++;
        if (RD_DATA !== 8'h20) begin n_fail++; $display("FAIL prio_pend: RD_DATA=%h expected 20", RD_DATA); end
        wr(8'h22, 8'h00);
        n_checks++;
        if (INT_R !== 1'b0) begin n_fail++; $display("FAIL prio_eoi0: INT_R=%b expected 0", INT_R); end
        tick();
        n_checks++;
        if (INT_R !== 1'b1) begin n_fail++; $display("FAIL prio_rereq: INT_R=%b expected 1", INT_R); end
        ack();
        rd(8'h22);
        n_checks++;
        if (RD_DATA !== 8'h0D) begin n_fail++; $display("FAIL prio_second: RD_DATA=%h expected 0D", RD_DATA); end
        wr(8'h22, 8'h00);
        tick();
    endtask

    task automatic test_mask();
        wr(8'h20, 8'h00);
        IRQ_IN = 8'h02;
        tick();
        IRQ_IN = 8'h00;
        tick(); tick();
        rd(8'h21);
        n_checks++;
        if (INT_R !== 1'b0 || RD_DATA !== 8'h02) begin n_fail++; $display("FAIL mask_held: INT_R=%b pend=%h expected 0/02", INT_R, RD_DATA); end
        wr(8'h20, 8'h02);
        n_checks++;
        if (INT_R !== 1'b0) begin n_fail++; $display("FAIL unmask_lat1: INT_R=%b expected 0", INT_R); end
        tick();
        n_checks++;
        if (INT_R !== 1'b1) begin n_fail++; $display("FAIL unmask_req: INT_R=%b expected 1", INT_R); end
        wr(8'h20, 8'h00);
        n_checks++;
        if (INT_R !== 1'b1) begin n_fail++; $display("FAIL withdraw_lat: INT_R=%b expected 1", INT_R); end
        tick();
        n_checks++;
        if (INT_R !== 1'b0) begin n_fail++; $display("FAIL withdraw: INT_R=%b expected 0", INT_R); end
        wr(8'h22, 8'h02);       // clear the still-pending bit while IDLE
        rd(8'h21);
        n_checks++;
        if (RD_DATA !== 8'h00) begin n_fail++; $display("FAIL eoi_idle_clr: RD_DATA=%h expected 00", RD_DATA); end
        wr(8'h21, 8'hFF);       // pending is read-only
        rd(8'h21);
        n_checks++;
        if (RD_DATA !== 8'h00) begin n_fail++; $display("FAIL pend_ro: RD_DATA=%h expected 00", RD_DATA); end
        wr(8'h20, 8'hFF);
    endtask

    task automatic test_back_to_back();
        IRQ_IN = 8'h08;
        tick();
        IRQ_IN = 8'h00;
        tick();
        // Grant source 3 while a higher-priority edge arrives on source 0.
        IRQ_IN = 8'h01;
        ack();
        IRQ_IN = 8'h00;
        rd(8'h22);
        n_checks++;
        if (RD_DATA !== 8'h0B) begin n_fail++; $display("FAIL b2b_grant: RD_DATA=%h expected 0B", RD_DATA); end
        rd(8'h21);
        n_checks++;
        if (RD_DATA !== 8'h01) begin n_fail++; $display("FAIL b2b_pend: RD_DATA=%h expected 01", RD_DATA); end
        wr(8'h22, 8'h00);
        tick();
        n_checks++;
        if (INT_R !== 1'b1) begin n_fail++; $display("FAIL b2b_rereq: INT_R=%b expected 1", INT_R); end
        ack();
        rd(8'h22);
        n_checks++;
        if (RD_DATA !== 8'h08) begin n_fail++; $display("FAIL b2b_second: RD_DATA=%h expected 08", RD_DATA); end
        wr(8'h22, 8'h00);
        tick();
    endtask

    task automatic test_set_beats_clear();
        IRQ_IN = 8'h10;
        wr(8'h22, 8'h10);
        IRQ_IN = 8'h00;
        rd(8'h21);
        n_checks++;
        if (RD_DATA !== 8'h10) begin n_fail++; $display("FAIL set_beats_clr: RD_DATA=%h expected 10", RD_DATA); end
        tick();
        n_checks++;
        if (INT_R !== 1'b1) begin n_fail++; $display("FAIL sbc_req: INT_R=%b expected 1", INT_R); end
    endtask

    task automatic test_reset_in_service();
        ack();                  // enter SERVICE for source 4
        IRQ_IN = 8'h81;
        tick();
        IRQ_IN = 8'h00;
        rd(8'h21);
        n_checks++;
        if (RD_DATA !== 8'h81) begin n_fail++; $display("FAIL svc_pend: RD_DATA=%h expected 81", RD_DATA); end
        rd(8'h22);
        n_checks++;
        if (RD_DATA !== 8'h0C) begin n_fail++; $display("FAIL svc_state: RD_DATA=%h expected 0C", RD_DATA); end
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        rd(8'h20);
        n_checks++;
        if (RD_DATA !== 8'h00 || INT_R !== 1'b0) begin n_fail++; $display("FAIL rst_mask: RD_DATA=%h INT_R=%b expected 00/0", RD_DATA, INT_R); end
        rd(8'h21);
        n_checks++;
        if (RD_DATA !== 8'h00) begin n_fail++; $display("FAIL rst_pend: RD_DATA=%h expected 00", RD_DATA); end
        rd(8'h22);
        n_checks++;
        if (RD_DATA !== 8'h00) begin n_fail++; $display("FAIL rst_eoi: RD_DATA=%h expected 00", RD_DATA); end
        ack();
        tick();
        rd(8'h22);
        n_checks++;
        if (RD_DATA !== 8'h00 || INT_R !== 1'b0) begin n_fail++; $display("FAIL ack_ignored: RD_DATA=%h INT_R=%b expected 00/0", RD_DATA, INT_R); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_back_to_back();
        test_set_beats_clear();
        test_reset_in_service();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
